// File: rtl/multiplier_core.sv
// Sequential unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product with fixed latency.
// Define RADIX4_EN to retire two multiplier bits per cycle (WIDTH must then be even).
module multiplier_core #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [2*WIDTH-1:0]   result,
  output logic                 op_done
);

`ifdef RADIX4_EN
  localparam int ITER = WIDTH / 2;
  localparam int STEP = 2;
`else
  localparam int ITER = WIDTH;
  localparam int STEP = 1;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [2*WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   w_bExt;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_accNext;
`ifdef RADIX4_EN
  logic [2*WIDTH-1:0]   r_b3;
  logic [2*WIDTH-1:0]   w_b3;
`endif

  assign w_bExt = {{WIDTH{1'b0}}, multiplicand};
`ifdef RADIX4_EN
  // 3B is formed once at accept so the iteration only ever selects, never multiplies.
  assign w_b3 = (w_bExt << 1) + w_bExt;
`endif

  always_comb begin
    w_addend = '0;
`ifdef RADIX4_EN
    case (r_a[1:0])
      2'd0:    w_addend = '0;
      2'd1:    w_addend = r_b;
      2'd2:    w_addend = r_b << 1;
      default: w_addend = r_b3;
    endcase
`else
    if (r_a[0]) w_addend = r_b;
`endif
    w_accNext = r_acc + w_addend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
      result  <= '0;
      op_done <= 1'b0;
`ifdef RADIX4_EN
      r_b3    <= '0;
`endif
    end else if (op_clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      result  <= '0;
      op_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_start) begin
            r_a     <= multiplier;
            r_b     <= w_bExt;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= BUSY;
`ifdef RADIX4_EN
            r_b3    <= w_b3;
`endif
          end
        end
        BUSY: begin
          r_acc   <= w_accNext;
          r_a     <= r_a >> STEP;
          r_b     <= r_b << STEP;
          r_count <= r_count + 1'b1;
`ifdef RADIX4_EN
          r_b3    <= r_b3 << STEP;
`endif
          // The final partial product goes straight to result so op_done and data appear together.
          if (r_count == LAST) begin
            result  <= w_accNext;
            op_done <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_core.sv
// Directed plus randomized bench for multiplier_core; products come from plain 128-bit arithmetic.
module tb_multiplier_core;

`ifdef RADIX4_EN
  localparam int LAT = 32;
`else
  localparam int LAT = 64;
`endif

  logic          clk;
  logic          reset_n;
  logic          op_start;
  logic          op_clear;
  logic [63:0]   multiplier;
  logic [63:0]   multiplicand;
  logic [127:0]  result;
  logic          op_done;

  int compared;
  int mismatched;

  multiplier_core #(.WIDTH(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .result       (result),
    .op_done      (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] refProduct(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa;
    logic [127:0] wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start an operation, confirm op_done is still low one cycle short of the latency, then check the product.
  task automatic runOp(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] exp);
    multiplier   = a;
    multiplicand = b;
    op_start     = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (LAT - 1) tick();
    check1({tag, "_early_done"}, op_done, 1'b0);
    tick();
    check1({tag, "_done"}, op_done, 1'b1);
    check128({tag, "_result"}, result, exp);
  endtask

  task automatic clearOp();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    compared     = 0;
    mismatched   = 0;
    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplier   = '0;
    multiplicand = '0;

    #12;
    check128("reset_result", result, 128'd0);
    check1("reset_done", op_done, 1'b0);
    reset_n = 1'b1;
    tick();

    // Reset mid-BUSY aborts the operation and returns to IDLE.
    multiplier   = 64'd9;
    multiplicand = 64'd9;
    op_start     = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check128("midbusy_reset_result", result, 128'd0);
    check1("midbusy_reset_done", op_done, 1'b0);
    #1;
    reset_n = 1'b1;
    repeat (LAT + 2) tick();
    check1("after_reset_idle_done", op_done, 1'b0);

    runOp("mul_5x4", 64'd5, 64'd4, 128'd20);
    for (int i = 0; i < 10; i++) begin
      op_start     = (i == 3);
      multiplier   = 64'd11;
      multiplicand = 64'd13;
      tick();
    end
    op_start = 1'b0;
    check1("hold_done", op_done, 1'b1);
    check128("hold_result", result, 128'd20);

    // Asynchronous reset from DONE with no clock edge in between.
    #1;
    reset_n = 1'b0;
    #1;
    check128("async_reset_result", result, 128'd0);
    check1("async_reset_done", op_done, 1'b0);
    #1;
    reset_n = 1'b1;

    runOp("mul_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    clearOp();
    check1("clear_done", op_done, 1'b0);
    check128("clear_result", result, 128'd0);

    // Clear during BUSY, then back-to-back start on the next edge.
    multiplier   = 64'd9;
    multiplicand = 64'd9;
    op_start     = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (29) tick();
    clearOp();
    check1("busy_clear_done", op_done, 1'b0);
    check128("busy_clear_result", result, 128'd0);
    runOp("mul_3x7", 64'd3, 64'd7, 128'd21);
    clearOp();

    // Start and clear together in IDLE must not launch anything.
    multiplier   = 64'd2;
    multiplicand = 64'd2;
    op_start     = 1'b1;
    op_clear     = 1'b1;
    tick();
    op_start = 1'b0;
    op_clear = 1'b0;
    repeat (LAT + 2) tick();
    check1("start_clear_done", op_done, 1'b0);
    check128("start_clear_result", result, 128'd0);

    // Operand and start changes during BUSY are ignored.
    multiplier   = 64'd6;
    multiplicand = 64'd7;
    op_start     = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (5) tick();
    multiplier   = 64'd1;
    multiplicand = 64'd1;
    op_start     = 1'b1;
    repeat (LAT - 6) tick();
    check1("change_early_done", op_done, 1'b0);
    tick();
    op_start = 1'b0;
    check1("change_done", op_done, 1'b1);
    check128("change_result", result, 128'd42);
    clearOp();

    runOp("mul_fact21", 64'h21C3_677C_82B4_0000, 64'd21, 128'h2_C507_7D36_B8C4_0000);
    clearOp();

    runOp("mul_zero", 64'd0, 64'hDEAD_BEEF_0000_1234, 128'd0);
    clearOp();

    for (int k = 0; k < 6; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      runOp($sformatf("rand%0d", k), ra, rb, refProduct(ra, rb));
      clearOp();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
